// File: rtl/arbitro_registro_compartido_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// Holds the FSM state encoding and the default sizing constants.
package arbitro_registro_compartido_pkg;

  localparam int unsigned ANCHO_DEF = 8;
  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned ID_W_DEF  = 2;

  // Code 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/arbitro_registro_compartido_selector_rr.sv
// Combinational round-robin selector: rotate-and-priority-encode.
// Ports:
//   i_req       per-requester request vector
//   i_ptr       index of the last served requester (search starts at i_ptr+1)
//   o_winner_c  first set request found searching i_ptr+1, i_ptr+2, ... mod N_REQ
//   o_any_req_c any request bit set
module selector_rr
  import arbitro_registro_compartido_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_winner_c,
  output logic             o_any_req_c
);

  logic              w_found;
  logic [ID_W-1:0]   w_idx;

  // Search order starts just after the last owner, wrapping modulo N_REQ.
  always_comb begin
    o_winner_c  = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    o_any_req_c = |i_req;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = ID_W'((32'(i_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found    = 1'b1;
        o_winner_c = w_idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_registro_compartido.sv
// Round-robin arbiter sharing one ANCHO-bit register among N_REQ requesters
// with a 4-phase req/ack handshake.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   req      per-requester level request
//   D        flattened requester data, slice i = D[i*ANCHO +: ANCHO]
//   clr      synchronous clear of Q/q_valid (FSM untouched)
//   gnt      one-hot grant
//   ack      one-hot single-cycle load acknowledge
//   Q        shared register
//   owner    index of requester that last wrote Q
//   q_valid  Q holds written data since last reset/clr
module arbitro_registro_compartido
  import arbitro_registro_compartido_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF,
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ANCHO-1:0] D,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [ANCHO-1:0]       Q,
  output logic [ID_W-1:0]        owner,
  output logic                   q_valid
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_ptr,   w_ptr_nxt;
  logic [ID_W-1:0]   r_sel,   w_sel_nxt;
  logic [N_REQ-1:0]  r_gnt,   w_gnt_nxt;
  logic [N_REQ-1:0]  r_ack,   w_ack_nxt;
  logic [ANCHO-1:0]  r_q,     w_q_nxt;
  logic [ID_W-1:0]   r_owner, w_owner_nxt;
  logic              r_q_valid, w_q_valid_nxt;

  logic [ID_W-1:0]   w_winner;
  logic              w_any_req;
  logic [ANCHO-1:0]  w_d_slice [N_REQ];

  // Unflatten requester data for indexed selection.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign w_d_slice[gi] = D[gi*ANCHO +: ANCHO];
  end

  selector_rr #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_selector_rr (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .o_winner_c  (w_winner),
    .o_any_req_c (w_any_req)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= ID_W'(N_REQ - 1);
      r_sel     <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_q       <= '0;
      r_owner   <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ack     <= w_ack_nxt;
      r_q       <= w_q_nxt;
      r_owner   <= w_owner_nxt;
      r_q_valid <= w_q_valid_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = r_gnt;
    w_ack_nxt     = '0;
    w_q_nxt       = r_q;
    w_owner_nxt   = r_owner;
    w_q_valid_nxt = r_q_valid;

    // Clear applies first so a same-cycle write below overrides it.
    if (clr) begin
      w_q_nxt       = '0;
      w_q_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_any_req) begin
          w_gnt_nxt   = N_REQ'(1) << w_winner;
          w_sel_nxt   = w_winner;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[r_sel]) begin
          w_q_nxt       = w_d_slice[r_sel];
          w_owner_nxt   = r_sel;
          w_q_valid_nxt = 1'b1;
          w_ack_nxt     = N_REQ'(1) << r_sel;
          w_state_nxt   = ST_WAIT_REL;
        end else begin
          // Withdrawn before load: ptr stays so priority is not consumed.
          w_gnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_REL: begin
        if (!req[r_sel]) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign Q       = r_q;
  assign owner   = r_owner;
  assign q_valid = r_q_valid;

endmodule
